// File: rtl/mem_bus_master.sv
// Single-outstanding initiator for the level-strobe / resp-pulse memory bus.
// Optional strobe watchdog is built in when MEM_BUS_MASTER_TIMEOUT_EN is defined.
module mem_bus_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_read,
   output logic                  mem_write,
   input  logic                  mem_resp,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic                  r_rsp_valid;
   logic                  r_rsp_error;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_busy;

   logic [1:0]            w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
   logic [DATA_WIDTH-1:0] w_mem_wdata_nxt;
   logic                  w_mem_read_nxt;
   logic                  w_mem_write_nxt;
   logic                  w_rsp_valid_nxt;
   logic                  w_rsp_error_nxt;
   logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;

   logic                  w_accept;
   logic                  w_misaligned;
   logic                  w_in_bus;
   logic                  w_expired;

   assign req_ready    = (r_state == S_IDLE) && !rst;
   assign w_accept     = req_valid && req_ready;
   assign w_misaligned = (req_addr[1:0] != 2'b00);
   assign w_in_bus     = (r_state == S_RD) || (r_state == S_WR);

`ifdef MEM_BUS_MASTER_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] r_to_cnt;
   logic [TO_W-1:0] w_to_cnt_nxt;

   assign w_expired = w_in_bus && (r_to_cnt == TO_LAST);

   // Watchdog count: cleared on bus entry, advances each unanswered strobe cycle.
   always_comb begin
      w_to_cnt_nxt = r_to_cnt;
      if (w_accept && !w_misaligned) begin
         w_to_cnt_nxt = {TO_W{1'b0}};
      end else if (w_in_bus && !mem_resp && !w_expired) begin
         w_to_cnt_nxt = r_to_cnt + TO_W'(1);
      end else begin
         w_to_cnt_nxt = r_to_cnt;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt <= {TO_W{1'b0}};
      end else begin
         r_to_cnt <= w_to_cnt_nxt;
      end
   end
`else
   // Without the watchdog a strobe waits for mem_resp indefinitely.
   assign w_expired = 1'b0 && (TIMEOUT >= 2);
`endif

   // Next-state and next-output decode for the bus transaction FSM.
   always_comb begin
      w_state_nxt     = r_state;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_mem_read_nxt  = r_mem_read;
      w_mem_write_nxt = r_mem_write;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_error_nxt = 1'b0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      case (r_state)
         S_IDLE: begin
            w_mem_read_nxt  = 1'b0;
            w_mem_write_nxt = 1'b0;
            if (w_accept) begin
               if (w_misaligned) begin
                  w_state_nxt = S_ERR;
               end else begin
                  w_mem_addr_nxt  = req_addr;
                  w_mem_wdata_nxt = req_wdata;
                  if (req_write) begin
                     w_mem_write_nxt = 1'b1;
                     w_state_nxt     = S_WR;
                  end else begin
                     w_mem_read_nxt  = 1'b1;
                     w_state_nxt     = S_RD;
                  end
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RD: begin
            // A response on the expiry edge still wins as a normal completion.
            if (mem_resp) begin
               w_mem_read_nxt  = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_rdata_nxt = mem_rdata;
               w_state_nxt     = S_IDLE;
            end else if (w_expired) begin
               w_mem_read_nxt  = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_error_nxt = 1'b1;
               w_rsp_rdata_nxt = {DATA_WIDTH{1'b0}};
               w_state_nxt     = S_IDLE;
            end else begin
               w_state_nxt = S_RD;
            end
         end
         S_WR: begin
            if (mem_resp) begin
               w_mem_write_nxt = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_rdata_nxt = {DATA_WIDTH{1'b0}};
               w_state_nxt     = S_IDLE;
            end else if (w_expired) begin
               w_mem_write_nxt = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_error_nxt = 1'b1;
               w_rsp_rdata_nxt = {DATA_WIDTH{1'b0}};
               w_state_nxt     = S_IDLE;
            end else begin
               w_state_nxt = S_WR;
            end
         end
         S_ERR: begin
            w_mem_read_nxt  = 1'b0;
            w_mem_write_nxt = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_error_nxt = 1'b1;
            w_rsp_rdata_nxt = {DATA_WIDTH{1'b0}};
            w_state_nxt     = S_IDLE;
         end
         default: begin
            w_mem_read_nxt  = 1'b0;
            w_mem_write_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any transaction without a response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_mem_addr  <= {ADDR_WIDTH{1'b0}};
         r_mem_wdata <= {DATA_WIDTH{1'b0}};
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_error <= 1'b0;
         r_rsp_rdata <= {DATA_WIDTH{1'b0}};
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_read  <= w_mem_read_nxt;
         r_mem_write <= w_mem_write_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_error <= w_rsp_error_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
      end
   end

   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign rsp_valid = r_rsp_valid;
   assign rsp_error = r_rsp_error;
   assign rsp_rdata = r_rsp_rdata;
   assign busy      = r_busy;

endmodule

// File: tb/tb_mem_bus_master.sv
// Table-driven bench for mem_bus_master with a response scoreboard and a bench-side responder.
module tb_mem_bus_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic        busy;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic        mem_resp;
   logic [31:0] mem_rdata;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          delay;      // strobe cycle in which mem_resp is pulsed; 0 = never
      logic [31:0] mrdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_strobe; // expected number of strobe-high cycles
      bit          b2b;
      bit          hold;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   vec_t vecs[$];
   rsp_t exp_q[$];

   mem_bus_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .busy(busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Scoreboard side: every response pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst) begin
         chk("one_strobe", {63'd0, mem_read && mem_write}, 64'd0);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               n_total++;
               n_bad++;
               $display("FAIL spurious_rsp: got rsp_valid=1 rdata=%0h want no response", rsp_rdata);
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               chk("sb_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
               chk("sb_error", {63'd0, rsp_error}, {63'd0, e.err});
            end
         end
      end
   end

   task automatic do_txn(input vec_t v, input string tag);
      int   guard;
      int   scnt;
      rsp_t e;
      if (v.b2b) chk({tag, "_b2b_ready"}, {63'd0, req_ready}, 64'd1);
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_ready_wait"}, {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1;
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      exp_q.push_back(e);
      @(negedge clk);
      if (!v.hold) begin
         req_valid = 1'b0;
         req_write = 1'($urandom_range(0, 1));
         req_addr  = $urandom;
         req_wdata = $urandom;
      end
      chk({tag, "_first_strobe"}, {63'd0, mem_read || mem_write}, {63'd0, v.exp_strobe != 0});
      chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
      chk({tag, "_ready_low"}, {63'd0, req_ready}, 64'd0);
      scnt  = 0;
      guard = 0;
      while ((mem_read || mem_write) && guard < 40) begin
         scnt++;
         guard++;
         chk({tag, "_rd_strobe"}, {63'd0, mem_read}, {63'd0, !v.wr});
         chk({tag, "_mem_addr"}, {32'd0, mem_addr}, {32'd0, v.addr});
         if (v.wr) chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, {32'd0, v.wdata});
         if (v.delay != 0 && scnt == v.delay) begin
            mem_resp  = 1'b1;
            mem_rdata = v.mrdata;
         end else begin
            mem_resp  = 1'b0;
            mem_rdata = $urandom;
         end
         @(negedge clk);
      end
      mem_resp = 1'b0;
      chk({tag, "_strobe_len"}, 64'(scnt), 64'(v.exp_strobe));
      if (v.exp_strobe == 0) begin
         chk({tag, "_err_gap"}, {63'd0, rsp_valid}, 64'd0);
         @(negedge clk);
      end
      chk({tag, "_rsp_latency"}, {63'd0, rsp_valid}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      vec_t v;
      // wr  addr          wdata         dly mrdata        exp_rdata     err strobe b2b hold
      vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'hFFFF_FFFF, 32'h0,         1'b0, 1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0040, 32'h0,         2, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 2, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 32'h0000_0044, 32'h0,         3, 32'h5A5A_0002, 32'h5A5A_0002, 1'b0, 3, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0080, 32'hCAFE_F00D, 5, 32'h1111_2222, 32'h0,         1'b0, 5, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         1, 32'h7777_7777, 32'h0,         1'b1, 0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0002, 32'h9999_9999, 1, 32'h7777_7777, 32'h0,         1'b1, 0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1, 1'b0, 1'b0});
`ifdef MEM_BUS_MASTER_TIMEOUT_EN
      vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,         0, 32'h0,         32'h0,         1'b1, 8, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0104, 32'h0F0F_0F0F, 0, 32'h0,         32'h0,         1'b1, 8, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0108, 32'h0,         8, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 8, 1'b0, 1'b0});
`else
      vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,        12, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 12, 1'b0, 1'b0});
`endif

      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      mem_resp  = 1'b0;
      mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_outs", {56'd0, rsp_valid, rsp_error, busy, mem_read, mem_write, 3'b000}, 64'd0);
      chk("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
      chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
      chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
      rst = 1'b0;
      #1;
      chk("rel_req_ready", {63'd0, req_ready}, 64'd1);
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         if (!vecs[i].b2b) repeat (2) @(negedge clk);
         do_txn(vecs[i], $sformatf("v%0d", i));
      end

      // Misaligned read followed by a stray mem_resp while idle.
      repeat (2) @(negedge clk);
      v = '{1'b0, 32'h0000_0013, 32'h0, 1, 32'h0, 32'h0, 1'b1, 0, 1'b0, 1'b0};
      do_txn(v, "mis");
      mem_resp  = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      mem_resp = 1'b0;
      chk("stray_no_rsp", {63'd0, rsp_valid}, 64'd0);
      chk("stray_no_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      chk("stray_no_rsp2", {63'd0, rsp_valid}, 64'd0);
      chk("stray_ready", {63'd0, req_ready}, 64'd1);

      // Reset two cycles into a read, then a late mem_resp after release.
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_0200;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_strobe_on", {63'd0, mem_read}, 64'd1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_read_clr", {63'd0, mem_read}, 64'd0);
      chk("abort_rsp_clr", {63'd0, rsp_valid}, 64'd0);
      chk("abort_busy_clr", {63'd0, busy}, 64'd0);
      chk("abort_ready_low", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_ready_rel", {63'd0, req_ready}, 64'd1);
      mem_resp  = 1'b1;
      mem_rdata = 32'hBEEF_0000;
      @(negedge clk);
      mem_resp = 1'b0;
      chk("late_no_rsp", {63'd0, rsp_valid}, 64'd0);
      chk("late_no_strobe", {63'd0, mem_read}, 64'd0);
      @(negedge clk);
      chk("late_no_rsp2", {63'd0, rsp_valid}, 64'd0);
      chk("late_ready", {63'd0, req_ready}, 64'd1);

      repeat (2) @(negedge clk);
      chk("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
